// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan driver: segment vector type,
// segment bit positions and the hex glyph table.
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam seg7_t SEG_OFF = 7'h00;

  // Active-high glyphs, bit order {g,f,e,d,c,b,a}, indexed by nibble value.
  localparam seg7_t GLYPH_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg7_glyph.sv
// Combinational hex nibble to active-high segment pattern lookup.
module seg7_glyph
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output seg7_t      glyph
);

  assign glyph = GLYPH_TABLE[nibble];

endmodule

// File: rtl/seg7_scan.sv
// Multiplexed N-digit seven-segment driver with per-frame snapshot and dead time.
// Optional leading-zero blanking is enabled by defining SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int DEAD_CYCLES    = 2,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] value_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blank_in,
  output logic [6:0]            seg_out,
  output logic                  dp_out,
  output logic [N_DIGITS-1:0]   an_out,
  output logic                  frame_tick
);

  localparam int   CNT_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int   IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic AN_INV  = (AN_ACTIVE_LOW != 0);

  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic [4*N_DIGITS-1:0] snap_value;
  logic [N_DIGITS-1:0]   snap_dp;
  logic [N_DIGITS-1:0]   snap_blank;

  logic                  frame_start;
  logic                  cnt_last;
  logic                  idx_last;
  logic [N_DIGITS-1:0]   blank_mask;
  logic [3:0]            cur_nibble;
  logic                  cur_dp;
  logic                  cur_blank;
  logic                  window_on;
  logic                  lit;
  seg7_t                 glyph;
  logic [N_DIGITS-1:0]   an_next;
  seg7_t                 seg_next;
  logic                  dp_next;

  assign frame_start = (cnt == '0) && (idx == '0);
  assign cnt_last    = (cnt == CNT_W'(REFRESH_DIV - 1));
  assign idx_last    = (idx == IDX_W'(N_DIGITS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      snap_value <= '0;
      snap_dp    <= '0;
      snap_blank <= '0;
    end else begin
      if (frame_start) begin
        snap_value <= value_in;
        snap_dp    <= dp_in;
        snap_blank <= blank_in;
      end
      if (cnt_last) begin
        cnt <= '0;
        idx <= idx_last ? '0 : idx + IDX_W'(1);
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic upper_zero;

  // Walk down from the top digit; stop blanking at the first non-zero nibble.
  always_comb begin
    blank_mask = snap_blank;
    upper_zero = 1'b1;
    for (int i = N_DIGITS - 1; i > 0; i--) begin
      upper_zero = upper_zero && (snap_value[4*i +: 4] == 4'h0);
      if (upper_zero) blank_mask[i] = 1'b1;
    end
  end
`else
  always_comb begin
    blank_mask = snap_blank;
  end
`endif

  always_comb begin
    cur_nibble = 4'h0;
    cur_dp     = 1'b0;
    cur_blank  = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nibble = snap_value[4*i +: 4];
        cur_dp     = snap_dp[i];
        cur_blank  = blank_mask[i];
      end
    end
  end

  seg7_glyph u_glyph (
    .nibble (cur_nibble),
    .glyph  (glyph)
  );

  assign window_on = (cnt >= CNT_W'(DEAD_CYCLES));
  assign lit       = window_on && !cur_blank;

  always_comb begin
    an_next = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      an_next[i] = lit && (idx == IDX_W'(i));
    end
    seg_next = lit ? glyph : SEG_OFF;
    dp_next  = lit && cur_dp;
  end

  // Output registers: polarity is applied here so idle levels track the parameters.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_out    <= {7{SEG_INV}};
      dp_out     <= SEG_INV;
      an_out     <= {N_DIGITS{AN_INV}};
      frame_tick <= 1'b0;
    end else begin
      seg_out    <= seg_next ^ {7{SEG_INV}};
      dp_out     <= dp_next ^ SEG_INV;
      an_out     <= an_next ^ {N_DIGITS{AN_INV}};
      frame_tick <= frame_start;
    end
  end

endmodule
